// File: rtl/sr_latch.sv
// Bank of WIDTH clocked SR cells with per-cell and sticky invalid (S=R=1) flags.
// Optional macro SR_LATCH_SYNC_EN adds a two-flop synchronizer on S and R.
module sr_latch #(
   parameter int WIDTH        = 1,
   parameter int INVALID_MODE = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] S,
   input  logic [WIDTH-1:0] R,
   input  logic             clr_sticky,
   output logic [WIDTH-1:0] Q,
   output logic [WIDTH-1:0] Qb,
   output logic [WIDTH-1:0] invalid,
   output logic             invalid_sticky
);

   // Out-of-range modes collapse onto NOR behaviour.
   localparam int MODE_EFF = ((INVALID_MODE < 0) || (INVALID_MODE > 3)) ? 0 : INVALID_MODE;

   logic [WIDTH-1:0] s_s;
   logic [WIDTH-1:0] r_s;
   logic [WIDTH-1:0] q_q,   q_d;
   logic [WIDTH-1:0] qb_q,  qb_d;
   logic [WIDTH-1:0] inv_q, inv_d;
   logic             sticky_q, sticky_d;

`ifdef SR_LATCH_SYNC_EN
   logic [WIDTH-1:0] s_meta_q, s_sync_q;
   logic [WIDTH-1:0] r_meta_q, r_sync_q;

   // Two-flop synchronizer on set and reset requests.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_meta_q <= {WIDTH{1'b0}};
         s_sync_q <= {WIDTH{1'b0}};
         r_meta_q <= {WIDTH{1'b0}};
         r_sync_q <= {WIDTH{1'b0}};
      end else begin
         s_meta_q <= S;
         s_sync_q <= s_meta_q;
         r_meta_q <= R;
         r_sync_q <= r_meta_q;
      end
   end

   assign s_s = s_sync_q;
   assign r_s = r_sync_q;
`else
   assign s_s = S;
   assign r_s = R;
`endif

   // Per-cell next-state resolution, including the S=R=1 policy.
   always_comb begin
      q_d   = q_q;
      qb_d  = qb_q;
      inv_d = {WIDTH{1'b0}};
      for (int i = 0; i < WIDTH; i++) begin
         case ({s_s[i], r_s[i]})
            2'b10: begin
               q_d[i]  = 1'b1;
               qb_d[i] = 1'b0;
            end
            2'b01: begin
               q_d[i]  = 1'b0;
               qb_d[i] = 1'b1;
            end
            2'b11: begin
               inv_d[i] = 1'b1;
               case (MODE_EFF)
                  1: begin
                     q_d[i]  = q_q[i];
                     qb_d[i] = qb_q[i];
                  end
                  2: begin
                     q_d[i]  = 1'b0;
                     qb_d[i] = 1'b1;
                  end
                  3: begin
                     q_d[i]  = 1'b1;
                     qb_d[i] = 1'b0;
                  end
                  default: begin
                     q_d[i]  = 1'b0;
                     qb_d[i] = 1'b0;
                  end
               endcase
            end
            default: begin
               q_d[i]  = q_q[i];
               qb_d[i] = qb_q[i];
            end
         endcase
      end
   end

   // Sticky flag: a new invalid beats a simultaneous clear.
   always_comb begin
      if (|inv_d) begin
         sticky_d = 1'b1;
      end else if (clr_sticky) begin
         sticky_d = 1'b0;
      end else begin
         sticky_d = sticky_q;
      end
   end

   // Output state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_q      <= {WIDTH{1'b0}};
         qb_q     <= {WIDTH{1'b1}};
         inv_q    <= {WIDTH{1'b0}};
         sticky_q <= 1'b0;
      end else begin
         q_q      <= q_d;
         qb_q     <= qb_d;
         inv_q    <= inv_d;
         sticky_q <= sticky_d;
      end
   end

   assign Q              = q_q;
   assign Qb             = qb_q;
   assign invalid        = inv_q;
   assign invalid_sticky = sticky_q;

endmodule

// File: tb/tb_sr_latch.sv
// Self-checking bench: five sr_latch instances (modes 0..3 and out-of-range 5)
// driven in parallel and compared against a cell-level reference model.
module tb_sr_latch;

   localparam int W  = 4;
   localparam int NM = 5;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [W-1:0] S, R;
   logic         clr_sticky;

   logic [W-1:0] q_o   [NM];
   logic [W-1:0] qb_o  [NM];
   logic [W-1:0] inv_o [NM];
   logic         stk_o [NM];

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   for (genvar m = 0; m < NM; m++) begin : g_dut
      sr_latch #(.WIDTH(W), .INVALID_MODE((m == 4) ? 5 : m)) u_dut (
         .clk            (clk),
         .rst_n          (rst_n),
         .S              (S),
         .R              (R),
         .clr_sticky     (clr_sticky),
         .Q              (q_o[m]),
         .Qb             (qb_o[m]),
         .invalid        (inv_o[m]),
         .invalid_sticky (stk_o[m])
      );
   end

   // Reference model: stored bit, "both low" flag for NOR leftovers, flags.
   int           mode_of [NM] = '{0, 1, 2, 3, 0};
   logic [W-1:0] eq  [NM];
   logic [W-1:0] eb  [NM];
   logic [W-1:0] ei  [NM];
   logic         es  [NM];
   logic [W-1:0] s_h1, s_h2, r_h1, r_h2;

   task automatic model_reset();
      for (int m = 0; m < NM; m++) begin
         eq[m] = '0; eb[m] = '0; ei[m] = '0; es[m] = 1'b0;
      end
      s_h1 = '0; s_h2 = '0; r_h1 = '0; r_h2 = '0;
   endtask

   task automatic model_edge(input logic [W-1:0] s_in, input logic [W-1:0] r_in, input logic clr);
      logic [W-1:0] se, re;
`ifdef SR_LATCH_SYNC_EN
      se = s_h2; re = r_h2;
      s_h2 = s_h1; r_h2 = r_h1;
      s_h1 = s_in; r_h1 = r_in;
`else
      se = s_in; re = r_in;
`endif
      for (int m = 0; m < NM; m++) begin
         for (int c = 0; c < W; c++) begin
            ei[m][c] = se[c] & re[c];
            if (se[c] && re[c]) begin
               if (mode_of[m] == 3) begin eq[m][c] = 1'b1; eb[m][c] = 1'b0; end
               else if (mode_of[m] == 2) begin eq[m][c] = 1'b0; eb[m][c] = 1'b0; end
               else if (mode_of[m] == 0) begin eq[m][c] = 1'b0; eb[m][c] = 1'b1; end
            end else if (se[c]) begin
               eq[m][c] = 1'b1; eb[m][c] = 1'b0;
            end else if (re[c]) begin
               eq[m][c] = 1'b0; eb[m][c] = 1'b0;
            end
         end
         if (ei[m] != '0) es[m] = 1'b1;
         else if (clr)    es[m] = 1'b0;
      end
   endtask

   task automatic chk(input string tag, input int m, input logic [W-1:0] obs, input logic [W-1:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s dut%0d observed=%h expected=%h", tag, m, obs, exp);
      end
   endtask

   task automatic check_all();
      for (int m = 0; m < NM; m++) begin
         chk("Q",      m, q_o[m],   eq[m]);
         chk("Qb",     m, qb_o[m],  ~eq[m] & ~eb[m]);
         chk("inv",    m, inv_o[m], ei[m]);
         chk("sticky", m, {{(W-1){1'b0}}, stk_o[m]}, {{(W-1){1'b0}}, es[m]});
      end
   endtask

   task automatic step(input logic [W-1:0] s_in, input logic [W-1:0] r_in, input logic clr);
      S = s_in; R = r_in; clr_sticky = clr;
      @(posedge clk);
      if (rst_n) model_edge(s_in, r_in, clr);
      #1;
      check_all();
   endtask

   task automatic settle(input logic [W-1:0] s_in, input logic [W-1:0] r_in);
      step(s_in, r_in, 1'b0);
`ifdef SR_LATCH_SYNC_EN
      step(s_in, r_in, 1'b0);
      step(s_in, r_in, 1'b0);
`endif
   endtask

   initial begin
      logic [W-1:0] rs, rr;
      S = '1; R = '0; clr_sticky = 1'b0; rst_n = 1'b1;
      #2;
      // Asynchronous reset with S held high.
      rst_n = 1'b0;
      model_reset();
      #1;
      check_all();
      step('1, '0, 1'b0);
      step('1, '0, 1'b0);
      rst_n = 1'b1;
      settle('1, '0);
      // Hold after set, then reset and hold.
      settle('0, '0);
      step('0, '0, 1'b0);
      settle('0, 4'b1111);
      settle('0, '0);
      // Per-cell independence: set cells 0 and 2.
      settle(4'b0101, 4'b0000);
      settle(4'b0010, 4'b0001);
      // Invalid from Q=1 on every cell, then release to hold.
      settle('1, '0);
      settle('1, '1);
      settle('0, '0);
      step('0, '0, 1'b0);
      // Clear sticky, then clear coinciding with a new invalid.
      settle('0, '0);
      step('0, '0, 1'b1);
      settle(4'b1000, 4'b1000);
      step(4'b1000, 4'b1000, 1'b1);
      step('0, '0, 1'b1);
      // Leave invalid directly into set and reset.
      settle('1, '1);
      settle(4'b0011, 4'b1100);
      // Randomized traffic with occasional asynchronous reset.
      for (int n = 0; n < 300; n++) begin
         rs = W'($urandom);
         rr = W'($urandom);
         if ($urandom_range(0, 39) == 0) begin
            #2;
            rst_n = 1'b0;
            model_reset();
            #1;
            check_all();
            step(rs, rr, 1'b0);
            rst_n = 1'b1;
         end else begin
            step(rs, rr, ($urandom_range(0, 3) == 0));
         end
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sr_latch.md
Name: sr_latch

Overview:
- Clocked, registered set/reset storage element; a bank of WIDTH independent SR cells sharing one clock and one reset.
- Each cell behaves as a NOR-style SR latch sampled on the rising clock edge. Outputs are true (Q) and complement (Qb).
- Both-asserted (invalid) conditions are flagged, per cell and sticky.
- Sits wherever a control bit must be set by one event and cleared by another (status flags, interrupt pending bits).

Parameters:
- WIDTH, 1, number of independent SR cells.
- INVALID_MODE, 0, resolution when S=R=1: 0 = Q=0 and Qb=0 (NOR behaviour); 1 = hold previous state; 2 = reset-dominant; 3 = set-dominant.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- S  input  WIDTH  set request, per cell.
- R  input  WIDTH  reset request, per cell.
- clr_sticky  input  1  synchronous clear of invalid_sticky.
- Q  output  WIDTH  stored state.
- Qb  output  WIDTH  complement output.
- invalid  output  WIDTH  per-cell: S=R=1 was sampled on the last edge.
- invalid_sticky  output  1  OR-accumulated invalid history.

Behaviour:
- Reset: rst_n low forces the following immediately, independent of clk:
  - Q=0, Qb=all 1s
  - invalid=0
  - invalid_sticky=0
- Reset release: the first update occurs on the first rising clk edge with rst_n high.
- All outputs are registered. An input change is visible on outputs one clk edge later. No combinational input-to-output path.
- Per cell i, at each rising edge:
  - S=0,R=0: hold; Q and Qb unchanged.
  - S=1,R=0: Q=1, Qb=0.
  - S=0,R=1: Q=0, Qb=1.
  - S=1,R=1: invalid[i]=1; Q/Qb resolved per INVALID_MODE:
    - mode 0: Q=0, Qb=0.
    - mode 1: hold.
    - mode 2: Q=0, Qb=1.
    - mode 3: Q=1, Qb=0.
- invalid[i] is 0 on any edge where not both S and R were 1.
- Qb=~Q in every case except INVALID_MODE=0 during an invalid condition.
- Leaving invalid under mode 0:
  - to S=R=0 (hold): the cell keeps Q=0, Qb=0 until the next set or reset, which restores complementarity.
  - directly to set or reset: normal set/reset values.
- invalid_sticky:
  - set on an edge where any invalid bit is being loaded as 1.
  - cleared by clr_sticky=1 on an edge.
  - simultaneous set and clear on the same edge: set wins.
- Cells are fully independent; no cross-cell interaction.
- Reset asserted mid-operation: outputs go to reset values at once; pending inputs are ignored until release.
- Illegal INVALID_MODE values (>3) are treated as 0.

Optional Feature:
- Macro: SR_LATCH_SYNC_EN.
- Defined:
  - S and R each pass through a two-flop synchronizer per bit before the SR logic, which makes the inputs safe to drive asynchronously.
  - Input-to-output latency is 3 clk edges.
  - Synchronizer flops reset to 0 asynchronously with rst_n.
  - invalid is evaluated on the synchronized values.
- Undefined: inputs are sampled directly; latency is 1 edge.

Test Plan:
- Reset: rst_n=0 with S=1 held -> Q=0, Qb=1, invalid=0, invalid_sticky=0 immediately and throughout; after release, Q=1 on the first edge.
- Hold: reset then S=0,R=0 for 3 edges -> Q=0, Qb=1 stable; after set, S=R=0 -> Q=1, Qb=0 held.
- Set then reset: S=1,R=0 -> Q=1, Qb=0 after 1 edge; S=0,R=1 -> Q=0, Qb=1 after 1 edge.
- Invalid, INVALID_MODE=0: S=1,R=1 -> Q=0, Qb=0, invalid=1, invalid_sticky=1; then S=R=0 -> Q=0, Qb=0, invalid=0, sticky stays 1.
- Modes 1/2/3 from Q=1 with S=R=1: mode 1 -> Q=1; mode 2 -> Q=0, Qb=1; mode 3 -> Q=1, Qb=0. In all three, invalid=1.
- Sticky and sync: clr_sticky=1 with S=R=1 on the same edge -> sticky stays 1; with SR_LATCH_SYNC_EN, a set pulse gives Q=1 3 edges later.
